adder_seq_ctrl: RTL and testbench
=================================

// Module: adder_seq_ctrl
// PURPOSE
//  Sequencer that time-multiplexes one adder_8bit instance to add or subtract two
//  NBYTES-wide operands byte-serially, LSB first, chaining carry through a register.
//  Sits between PS GPIO (operands and start) and the adder datapath in the PL.
//  Returns the full-width result, carry-out, signed overflow and a one-cycle done pulse.
// PARAMETERS
//  NBYTES   4   operand width in bytes (legal range 1..16); W = 8*NBYTES
// PORTS
//  clk      in   1   single fabric clock; all state changes on rising edge
//  rst_n    in   1   asynchronous active-low reset
//  start    in   1   request; sampled only in IDLE
//  sub      in   1   0 = A+B, 1 = A-B (two's complement); sampled with start
//  op_a     in   W   operand A; sampled with start
//  op_b     in   W   operand B; sampled with start
//  busy     out  1   high in RUN and DONE
//  done     out  1   one-cycle pulse: result, cout and ovf valid
//  result   out  W   sum or difference, registered
//  cout     out  1   final carry; for sub, 1 = no borrow
//  ovf      out  1   signed overflow of the W-bit operation
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, cout, ovf = 0; result = 0; byte index = 0; carry reg = 0.
//  States IDLE -> RUN -> DONE -> IDLE. Encoding is binary.
//  IDLE: on an edge with start=1, latch op_a, op_b and sub. Set carry reg = sub and
//    index = 0, then go to RUN. Holding start high gives exactly one accept per pass
//    through IDLE.
//  RUN: adder inputs are A = a_byte[index], B = b_byte[index] ^ {8{sub_q}}, Cin = carry reg.
//    Each edge writes S into result[8*index +: 8], loads Cout into the carry reg and
//    increments index.
//    On the edge that writes byte NBYTES-1: cout <= adder Cout; ovf <= (A[7] == Beff[7])
//    && (S[7] != A[7]); state <= DONE.
//  DONE: done=1 for exactly one cycle, then IDLE next edge. result, cout and ovf hold
//    until the next accepted start overwrites them byte by byte.
//  Latency: start-sampling edge plus NBYTES edges, so done is visible NBYTES+1 edges
//    after the accept edge. Throughput is one op per NBYTES+2 cycles.
//  start in RUN or DONE is ignored and not queued. Operand changes after the accept
//    edge have no effect.
//  result bytes not yet written during RUN keep their previous values. Consumers must
//    use only done.
//  NBYTES=1: RUN lasts one edge, so done comes 2 edges after accept.
//  rst_n low mid-RUN: immediate return to reset values. No done pulse; the partial
//    result is discarded.
//  Arithmetic: all widths exact. No carry-in port; Cin of byte 0 is sub.
//    Carry between bytes is registered, never combinational across cycles.
// STRUCTURE
//  adder_seq_pkg: state localparams (ST_IDLE, ST_RUN, ST_DONE), ST_W, and the
//    function IDX_W(NBYTES) = clog2, minimum 1.
//  Sub-module: one adder_8bit instance (A, B, Cin, S, Cout). No other hierarchy.
//    Index counter, operand registers and FSM are local.
// TESTING (NBYTES=4)
//  T1 add: op_a=0x0000_00FF, op_b=0x0000_0001, sub=0 -> done at accept+5;
//    result=0x0000_0100, cout=0, ovf=0.
//  T2 carry out / overflow: 0xFFFF_FFFF + 0x0000_0001 -> result=0, cout=1, ovf=0.
//    0x7FFF_FFFF + 1 -> result=0x8000_0000, cout=0, ovf=1.
//  T3 subtract: 5 - 7, sub=1 -> result=0xFFFF_FFFE, cout=0 (borrow), ovf=0.
//    0x8000_0000 - 1 -> result=0x7FFF_FFFF, cout=1, ovf=1.
//  T4 start held high 20 cycles with 1+1 -> exactly 3 done pulses, 6 cycles apart,
//    result=2 each time. Operands changed mid-RUN do not alter result.
//  T5 rst_n pulsed low on the 2nd RUN cycle -> busy, done, result, cout, ovf = 0 at
//    once. A new start then completes normally: 0x1234_5678 + 0x1111_1111 = 0x2345_6789.
//  T6 random 1000 ops, both modes, random start gaps -> scoreboard matches {cout,result}
//    and ovf. done is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/adder_seq_pkg.sv
// Shared state encoding and sizing helper for the byte-serial add/sub sequencer.
package adder_seq_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-index width: clog2 of the byte count, never below one bit.
  function automatic int unsigned IDX_W(input int unsigned nbytes);
    return (nbytes <= 1) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple adder slice with carry in/out; the sequencer reuses it once per byte.
module adder_8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {8'd0, Cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Byte-serial NBYTES-wide add/subtract using one shared 8-bit adder, LSB byte first,
// with the inter-byte carry held in a register.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter  int unsigned NBYTES = 4,
  localparam int unsigned W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int unsigned    IW       = IDX_W(NBYTES);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NBYTES - 1);

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    sub_q, sub_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d;
  logic [NBYTES-1:0][7:0]  b_q, b_d;
  logic [NBYTES-1:0][7:0]  res_q, res_d;

  logic [7:0] add_a, add_b, add_s;
  logic       add_co;

  // Subtraction is A + ~B + 1: operand B is inverted per byte, the +1 enters as carry-in of byte 0.
  assign add_a = a_q[idx_q];
  assign add_b = b_q[idx_q] ^ {8{sub_q}};

  adder_8bit u_adder (
    .A    (add_a),
    .B    (add_b),
    .Cin  (carry_q),
    .S    (add_s),
    .Cout (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        res_d[idx_q] = add_s;
        carry_d      = add_co;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = add_co;
          ovf_d   = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign result = res_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl at NBYTES=4: directed corner cases plus randomized ops
// checked against a full-width arithmetic reference.
module tb_adder_seq_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_seq_ctrl #(.NBYTES(NB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  // Reference: exact W+1-bit unsigned sum for {cout,result}; signed overflow from 64-bit signed math.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] full;
    longint     sa, sb, sr;
    logic       o;
    full = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = s ? (sa - sb) : (sa + sb);
    o  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    return {o, full};
  endfunction

  // Waits for idle, issues one start, returns outputs at done and edges counted from the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] r, output logic c, output logic o, output int lat);
    int g;
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    r = result; c = cout; o = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    #1;
    vectors++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      miscompares++;
      $display("FAIL reset_async: busy=%b done=%b cout=%b ovf=%b result=%h, required all 0",
               busy, done, cout, ovf, result);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      miscompares++;
      $display("FAIL reset_held: busy=%b done=%b cout=%b ovf=%b result=%h, required all 0",
               busy, done, cout, ovf, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5], tb [5], tr [5];
    logic         ts [5], tc [5], to [5];
    logic [W-1:0] r;
    logic         c, o;
    int           lat;
    ta = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    tb = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
    ts = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tr = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    to = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], r, c, o, lat);
      vectors++;
      if (lat !== int'(NB + 1)) begin
        miscompares++;
        $display("FAIL directed%0d_latency: got %0d edges, required %0d", i, lat, NB + 1);
      end
      vectors++;
      if (r !== tr[i]) begin
        miscompares++;
        $display("FAIL directed%0d_result: got %h, required %h", i, r, tr[i]);
      end
      vectors++;
      if ({c, o} !== {tc[i], to[i]}) begin
        miscompares++;
        $display("FAIL directed%0d_flags: got cout=%b ovf=%b, required cout=%b ovf=%b",
                 i, c, o, tc[i], to[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nd, first, g;
    int edges [$];
    nd = 0;
    @(posedge clk); #1;
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    sub = 1'b0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      start = 1'b1;
      if (((m - 1) % 6) >= 1 && ((m - 1) % 6) <= 4) begin
        op_a = $urandom; op_b = $urandom;
      end else begin
        op_a = 32'd1; op_b = 32'd1;
      end
      @(posedge clk); #1;
      if (done) begin
        edges.push_back(m);
        nd++;
        vectors++;
        if ({cout, ovf, result} !== {2'b00, 32'd2}) begin
          miscompares++;
          $display("FAIL held_start_result: got cout=%b ovf=%b result=%h, required 0 0 00000002",
                   cout, ovf, result);
        end
      end
    end
    @(negedge clk);
    start = 1'b0; op_a = 32'd1; op_b = 32'd1;
    vectors++;
    if (nd !== 3) begin
      miscompares++;
      $display("FAIL held_start_count: got %0d done pulses, required 3", nd);
    end
    first = (edges.size() > 0) ? edges[0] : -1;
    vectors++;
    if (first !== int'(NB + 1)) begin
      miscompares++;
      $display("FAIL held_start_first: first done after edge %0d, required %0d", first, NB + 1);
    end
    for (int k = 1; k < edges.size(); k++) begin
      vectors++;
      if (edges[k] - edges[k-1] !== int'(NB + 2)) begin
        miscompares++;
        $display("FAIL held_start_spacing: pulses %0d cycles apart, required %0d",
                 edges[k] - edges[k-1], NB + 2);
      end
    end
    g = 0;
    while (busy && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] r;
    logic         c, o;
    int           lat;
    run_op(32'hF000_0000, 32'h2000_0001, 1'b0, r, c, o, lat);
    vectors++;
    if ({c, r} !== {1'b1, 32'h1000_0001}) begin
      miscompares++;
      $display("FAIL prereset_op: got cout=%b result=%h, required 1 10000001", c, r);
    end
    @(posedge clk); #1;
    @(negedge clk);
    op_a = 32'h1234_5678; op_b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, cout, ovf, result} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_run: busy=%b done=%b cout=%b ovf=%b result=%h, required all 0",
               busy, done, cout, ovf, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, r, c, o, lat);
    vectors++;
    if ({lat == int'(NB + 1), c, o, r} !== {1'b1, 1'b0, 1'b0, 32'h2345_6789}) begin
      miscompares++;
      $display("FAIL post_reset_op: got lat=%0d cout=%b ovf=%b result=%h, required 5 0 0 23456789",
               lat, c, o, r);
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [W-1:0] a, b, r;
    logic         s, c, o;
    logic [W+1:0] exp;
    int           lat;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      a = pick_operand();
      b = pick_operand();
      s = 1'($urandom_range(0, 1));
      exp = model(a, b, s);
      run_op(a, b, s, r, c, o, lat);
      vectors++;
      if ({o, c, r} !== exp || lat !== int'(NB + 1)) begin
        miscompares++;
        $display("FAIL random%0d: a=%h b=%h sub=%b got ovf=%b cout=%b result=%h lat=%0d, required ovf=%b cout=%b result=%h lat=%0d",
                 n, a, b, s, o, c, r, lat, exp[W+1], exp[W], exp[W-1:0], NB + 1);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL random%0d_done_width: done=%b one cycle after pulse, required 0", n, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
